// File: rtl/mem_resp_buf.sv
// Response FIFO between pipelined main memory and the cache-side consumers.
// Holds line responses with their IDs, retires on ack, warns memory early via o_mem_full.
module mem_resp_buf #(
    parameter int LINE_BYTES  = 16,
    parameter int ID_WIDTH    = 4,
    parameter int DEPTH       = 4,
    parameter int FULL_MARGIN = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_mem_enable,
    input  logic [LINE_BYTES*8-1:0]       i_mem_data,
    input  logic [ID_WIDTH-1:0]           i_mem_id,
    output logic                          o_mem_full,
    input  logic                          i_flush,
    output logic                          o_resp_enable,
    output logic [LINE_BYTES*8-1:0]       o_resp_data,
    output logic [ID_WIDTH-1:0]           o_resp_id,
    input  logic                          i_resp_ack,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic                          o_overflow
);
    localparam int DW = LINE_BYTES * 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0]       r_data [DEPTH];
    logic [ID_WIDTH-1:0] r_id   [DEPTH];
    logic [PW-1:0]       r_rd_ptr;
    logic [PW-1:0]       r_wr_ptr;
    logic [CW-1:0]       r_count;
    logic                r_overflow;

    logic w_pop;
    logic w_push;
    logic w_at_depth;
    logic w_drop;

    assign w_at_depth = (r_count == CW'(DEPTH));
    assign w_pop      = i_resp_ack && (r_count != '0);
    // A pop in the same edge frees the slot, so a push at full is still accepted.
    assign w_push     = i_mem_enable && (!w_at_depth || w_pop);
    assign w_drop     = i_mem_enable && w_at_depth && !w_pop;

    // Storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_data[r_wr_ptr] <= i_mem_data;
            r_id[r_wr_ptr]   <= i_mem_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_resp_enable = (r_count != '0);
    assign o_resp_data   = o_resp_enable ? r_data[r_rd_ptr] : '0;
    assign o_resp_id     = o_resp_enable ? r_id[r_rd_ptr] : '0;
    assign o_count       = r_count;
    assign o_overflow    = r_overflow;
    assign o_mem_full    = (r_count >= CW'(DEPTH - FULL_MARGIN));

endmodule

// File: doc/mem_resp_buf.md
Name: mem_resp_buf

Overview:
- Response buffer between the pipelined main memory and the two cache-side consumers (instruction and data memory engines).
- Captures every line-sized response the memory emits (data plus request ID) into a circular FIFO and presents the oldest entry to the consumers.
- Retires an entry only on an explicit consumer ack.
- Raises a credit-style full signal back to the memory so that responses already in flight never find the buffer without space.

Parameters:
- LINE_BYTES, 16, bytes per cache line; data width is LINE_BYTES*8.
- ID_WIDTH, 4, width of the request/response ID.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- FULL_MARGIN, 1, free entries reserved for in-flight responses; must be less than DEPTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset (rst=0 resets).
- i_mem_enable  in  1  memory presents a valid response this cycle (push request).
- i_mem_data  in  LINE_BYTES*8  response line data.
- i_mem_id  in  ID_WIDTH  response ID.
- o_mem_full  out  1  back-pressure to memory: stop issuing new requests.
- i_flush  in  1  synchronous discard of all buffered entries.
- o_resp_enable  out  1  head entry valid.
- o_resp_data  out  LINE_BYTES*8  head entry data.
- o_resp_id  out  ID_WIDTH  head entry ID.
- i_resp_ack  in  1  consumer accepted the head entry (pop request).
- o_count  out  $clog2(DEPTH)+1  current occupancy.
- o_overflow  out  1  sticky error: a push was dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - rd_ptr=0, wr_ptr=0, count=0, overflow=0.
  - o_resp_enable=0, o_resp_data=0, o_resp_id=0, o_mem_full=0, o_count=0, o_overflow=0.
  - Entry storage is not cleared.
  - Assertion mid-operation discards all entries immediately. After release, the first push is visible one cycle later.
- Storage: DEPTH entries of {data, id}; pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is held separately.
- Push:
  - push = i_mem_enable && (count<DEPTH || pop).
  - Writes entry[wr_ptr] and increments wr_ptr.
- Pop:
  - pop = i_resp_ack && count!=0.
  - Increments rd_ptr.
  - An ack while empty is ignored: no pointer change, no error.
- Count update:
  - count += push - pop.
  - Simultaneous push and pop leaves count unchanged and is legal at count==DEPTH (the pop frees the slot in the same edge).
  - With count==0, a simultaneous push and ack: the ack is ignored and the push is stored.
- Overflow: i_mem_enable && count==DEPTH && !pop drops the data, sets overflow (sticky until reset) and leaves the pointers unchanged.
- Outputs are combinational from registered state:
  - o_resp_enable = (count!=0).
  - o_resp_data/o_resp_id = entry[rd_ptr]; driven 0 when empty.
  - o_count = count.
  - Latency: a push at edge N becomes visible after edge N (no same-cycle bypass from i_mem_* to o_resp_*).
- Full: o_mem_full = (count >= DEPTH-FULL_MARGIN), computed from registered count.
- Flush:
  - i_flush=1 at an edge sets rd_ptr=wr_ptr=0 and count=0.
  - A same-cycle push or pop is discarded; overflow is not set by it.
  - Flush has priority over everything except reset.
- Entry order is strictly FIFO; IDs are not reordered or filtered. The consumer matches o_resp_id against its own outstanding ID.

Test Plan:
1. Reset then single push: release rst; push data=0x...0A, id=3 at edge 1 -> after edge 1 o_resp_enable=1, o_resp_id=3, o_count=1; ack at edge 2 -> o_resp_enable=0, o_count=0.
2. Fill and full threshold (DEPTH=4, FULL_MARGIN=1): push ids 1,2,3 on consecutive edges, no ack -> o_mem_full=1 after the third push, o_count=3. Push id 4 -> o_count=4. Pop four times -> ids appear in order 1,2,3,4, and o_mem_full drops when count reaches 2.
3. Simultaneous push/pop at full: count=4, push id 9 with ack -> head advances, o_count stays 4, o_overflow=0. Draining shows id 9 last.
4. Overflow: count=4, push id 7 with no ack -> o_overflow=1 and o_count=4; id 7 never appears when draining. o_overflow stays 1 until rst=0.
5. Wrap-around: push/pop 10 entries in a ping-pong pattern (ids 0..9) -> every id out in order, pointers wrap, o_count never exceeds 1.
6. Flush and async reset: count=3, assert i_flush together with push id 5 -> o_count=0, o_resp_enable=0, id 5 lost, o_overflow=0. Refill to 2, pulse rst=0 mid-cycle -> outputs go to 0 before the next edge.
